// File: rtl/down_counter_sync_ld.sv
// rtl/down_counter_sync_ld.sv - loadable down counter with terminal-count pulse (option: DOWN_COUNTER_AUTORELOAD_EN)
module down_counter_sync_ld #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             busy
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             tc_nxt;

`ifdef DOWN_COUNTER_AUTORELOAD_EN
   logic [WIDTH-1:0] rld, rld_nxt;

   // Reload register keeps the last loaded start value for periodic restarts
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rld <= ZERO;
      else     rld <= rld_nxt;
   end
`endif

   // State, count and terminal-count registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         q     <= ZERO;
         tc    <= 1'b0;
      end else begin
         state <= state_nxt;
         q     <= q_nxt;
         tc    <= tc_nxt;
      end
   end

   // Next-state logic: load beats enable; tc is a one-cycle pulse on the 1->0 step
   always_comb begin
      state_nxt = state;
      q_nxt     = q;
      tc_nxt    = 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      rld_nxt   = rld;
`endif
      if (load) begin
         q_nxt     = load_val;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
         rld_nxt   = load_val;
`endif
         state_nxt = (load_val != ZERO) ? RUN : IDLE;
      end else if (state == RUN && en) begin
         if (q > ONE) begin
            q_nxt = q - ONE;
         end else if (q == ONE) begin
            q_nxt  = ZERO;
            tc_nxt = 1'b1;
`ifndef DOWN_COUNTER_AUTORELOAD_EN
            state_nxt = IDLE;
`endif
         end else begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            q_nxt = rld;
`else
            // RUN at zero cannot occur in one-shot mode; park safely at zero
            state_nxt = IDLE;
`endif
         end
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_down_counter_sync_ld.sv
// tb/tb_down_counter_sync_ld.sv - scoreboard bench for down_counter_sync_ld
module tb_down_counter_sync_ld;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic [3:0] q;
   logic       tc;
   logic       busy;

   typedef struct packed {
      logic [3:0] q;
      logic       tc;
      logic       busy;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   logic [3:0] m_q;
   logic [3:0] m_rld;
   logic       m_tc;
   logic       m_run;

   down_counter_sync_ld #(.WIDTH(4)) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .load(load),
      .load_val(load_val),
      .q(q),
      .tc(tc),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_q = 4'd0; m_rld = 4'd0; m_tc = 1'b0; m_run = 1'b0;
   endtask

   // Reference behaviour for one clock edge with the given inputs
   task automatic model_edge(input logic e, input logic l, input logic [3:0] lv);
      if (l) begin
         m_q = lv; m_rld = lv; m_tc = 1'b0; m_run = (lv != 4'd0);
      end else if (m_run && e) begin
         if (m_q == 4'd0) begin
            m_q = m_rld; m_tc = 1'b0;
         end else begin
            m_q  = m_q - 4'd1;
            m_tc = (m_q == 4'd0);
`ifndef DOWN_COUNTER_AUTORELOAD_EN
            if (m_tc) m_run = 1'b0;
`endif
         end
      end else begin
         m_tc = 1'b0;
      end
   endtask

   // Drive one cycle, push expectation, compare after the edge
   task automatic step(input logic e, input logic l, input logic [3:0] lv, input string tag);
      exp_t x;
      en = e; load = l; load_val = lv;
      model_edge(e, l, lv);
      sb.push_back(exp_t'{m_q, m_tc, m_run});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 0, 1);
      end else begin
         x = sb.pop_front();
         chk({tag, "_q"}, int'(q), int'(x.q));
         chk({tag, "_tc"}, int'(tc), int'(x.tc));
         chk({tag, "_busy"}, int'(busy), int'(x.busy));
      end
      en = 1'b0; load = 1'b0;
   endtask

   initial begin
      int os_q[9];
      int tc_cnt;
      logic prev_tc;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_q", int'(q), 0);
      chk("rst_tc", int'(tc), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 1'b0;

      // Asynchronous reset mid-count at q=5
      step(1'b0, 1'b1, 4'd7, "ar_ld");
      step(1'b1, 1'b0, 4'd0, "ar_c");
      step(1'b1, 1'b0, 4'd0, "ar_c");
      chk("ar_q5", int'(q), 5);
      #2 rst = 1'b1;
      #1;
      chk("ar_async_q", int'(q), 0);
      chk("ar_async_tc", int'(tc), 0);
      chk("ar_async_busy", int'(busy), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'd0, "ar_post");
      chk("ar_post_q_lit", int'(q), 0);

`ifndef DOWN_COUNTER_AUTORELOAD_EN
      // One-shot: 3,2,1,0 then hold 0
      os_q = '{3, 2, 1, 0, 0, 0, 0, 0, 0};
      tc_cnt = 0;
      step(1'b1, 1'b1, 4'd3, "os");
      chk("os_lit0", int'(q), os_q[0]);
      for (int i = 1; i < 9; i++) begin
         step(1'b1, 1'b0, 4'd0, "os");
         chk("os_lit", int'(q), os_q[i]);
         if (tc) tc_cnt++;
         if (i == 3) begin
            chk("os_tc_at0", int'(tc), 1);
            chk("os_busy_fall", int'(busy), 0);
         end
      end
      chk("os_tc_count", tc_cnt, 1);
`else
      // Auto-reload: 2,1,0,2,1,0,2,1,0 with busy held
      os_q = '{2, 1, 0, 2, 1, 0, 2, 1, 0};
      tc_cnt = 0;
      step(1'b1, 1'b1, 4'd2, "arl");
      chk("arl_lit0", int'(q), os_q[0]);
      for (int i = 1; i < 9; i++) begin
         step(1'b1, 1'b0, 4'd0, "arl");
         chk("arl_lit", int'(q), os_q[i]);
         chk("arl_tc_lit", int'(tc), (os_q[i] == 0) ? 1 : 0);
         chk("arl_busy_lit", int'(busy), 1);
      end
`endif

      // Enable gating: 4,3,3,3,2,1,0
      step(1'b0, 1'b1, 4'd4, "eg");
      chk("eg_lit_load", int'(q), 4);
      step(1'b1, 1'b0, 4'd0, "eg");
      step(1'b0, 1'b0, 4'd0, "eg");
      step(1'b0, 1'b0, 4'd0, "eg");
      chk("eg_lit_hold", int'(q), 3);
      step(1'b1, 1'b0, 4'd0, "eg");
      step(1'b1, 1'b0, 4'd0, "eg");
      step(1'b1, 1'b0, 4'd0, "eg");
      chk("eg_lit_zero", int'(q), 0);
      chk("eg_lit_tc", int'(tc), 1);

      // Load priority / restart, then load of zero
      step(1'b1, 1'b1, 4'd5, "lp");
      step(1'b1, 1'b0, 4'd0, "lp");
      step(1'b1, 1'b0, 4'd0, "lp");
      step(1'b1, 1'b0, 4'd0, "lp");
      chk("lp_lit_q2", int'(q), 2);
      step(1'b1, 1'b1, 4'd9, "lp");
      chk("lp_lit_q9", int'(q), 9);
      chk("lp_lit_notc", int'(tc), 0);
      step(1'b1, 1'b1, 4'd0, "lz");
      chk("lz_lit_q", int'(q), 0);
      chk("lz_lit_busy", int'(busy), 0);
      chk("lz_lit_tc", int'(tc), 0);

      // Boundary: load on the 1->0 edge wins, no tc, no underflow
      step(1'b1, 1'b1, 4'd1, "bd");
      step(1'b1, 1'b1, 4'd15, "bd");
      chk("bd_lit_q15", int'(q), 15);
      chk("bd_lit_notc", int'(tc), 0);
      step(1'b0, 1'b1, 4'd0, "bd");
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 4'd0, "bd_sat");
         chk("bd_lit_noflow", int'(q), 0);
      end

      // Random traffic through the scoreboard, plus a tc-pulse invariant
      prev_tc = 1'b0;
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
              4'($urandom_range(0, 15)), "rnd");
         if (prev_tc && tc) chk("rnd_tc_double", 1, 0);
         prev_tc = tc;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
